// File: rtl/cdb_arbiter_pkg.sv
// Shared types and defaults for the completion stage (FU results -> CDB).
// Provides FUNC_OUTPUT, the common FU result / CDB slot payload, and the
// default NUM_FU / CDB_WIDTH next to the multiplier depth MULT_STAGES.
`ifndef MULT_STAGES
`define MULT_STAGES 4
`endif
`ifndef NUM_FU
`define NUM_FU 4
`endif
`ifndef CDB_WIDTH
`define CDB_WIDTH 2
`endif

package cdb_arbiter_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PRF_IDX_W = 6;
  localparam int unsigned ROB_IDX_W = 5;

  // value_valid=0 marks an x0 destination: still broadcast to retire the ROB entry
  typedef struct packed {
    logic                 valid;
    logic                 value_valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PRF_IDX_W-1:0] dest_prf;
    logic [XLEN-1:0]      value;
  } FUNC_OUTPUT;

endpackage

// File: rtl/cdb_arbiter_rr_select_k.sv
// Combinational round-robin select of up to K requesters out of N.
// Scan order is i_ptr, i_ptr+1, ... mod N; the first K requesters win.
// Ports:
//   i_req        request vector
//   i_ptr        current round-robin start index
//   o_grant      granted requesters
//   o_slot_oh    per slot, one-hot index of the k-th grant in scan order
//   o_slot_valid per slot, slot carries a grant
//   o_next_ptr   one past the last grant, or i_ptr when nothing was granted
module rr_select_k #(
  parameter int unsigned N = 4,
  parameter int unsigned K = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [N-1:0]  o_slot_oh [K],
  output logic [K-1:0]  o_slot_valid,
  output logic [PW-1:0] o_next_ptr
);

  int   w_pos;
  int   w_cnt;
  int   w_last;
  logic w_any;

  // Walk the rotated order, filling slots in order until K grants are made
  always_comb begin
    o_grant      = '0;
    o_slot_valid = '0;
    for (int k = 0; k < int'(K); k++) o_slot_oh[k] = '0;
    w_pos  = 0;
    w_cnt  = 0;
    w_last = 0;
    w_any  = 1'b0;
    for (int j = 0; j < int'(N); j++) begin
      w_pos = int'(i_ptr) + j;
      if (w_pos >= int'(N)) w_pos = w_pos - int'(N);
      for (int i = 0; i < int'(N); i++) begin
        if (w_pos == i && i_req[i] && w_cnt < int'(K)) begin
          o_grant[i] = 1'b1;
          for (int k = 0; k < int'(K); k++) begin
            if (w_cnt == k) begin
              o_slot_oh[k][i] = 1'b1;
              o_slot_valid[k] = 1'b1;
            end
          end
          w_last = i;
          w_any  = 1'b1;
          w_cnt  = w_cnt + 1;
        end
      end
    end
    if (!w_any) o_next_ptr = i_ptr;
    else if (w_last + 1 >= int'(N)) o_next_ptr = '0;
    else o_next_ptr = PW'(w_last + 1);
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Completion-stage arbiter: grants up to CDB_WIDTH valid FU results per cycle
// in rotating priority, acknowledges them on fu_sel (same cycle) and registers
// them onto the CDB (next cycle).
// Ports:
//   clock, reset   clock; synchronous active-high reset
//   squash         mispredict flush: no grants, CDB cleared next cycle
//   cdb_stall      downstream busy: no grants, CDB cleared next cycle
//   fu_out         FU results, valid held until acknowledged
//   fu_sel         combinational per-FU acknowledge
//   cdb            registered broadcast slots, slot k = k-th grant in scan order
//   cdb_count      registered number of valid CDB slots
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU    = `NUM_FU,
  parameter int unsigned CDB_WIDTH = `CDB_WIDTH,
  localparam int unsigned CNT_W = $clog2(CDB_WIDTH + 1),
  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              squash,
  input  logic              cdb_stall,
  input  FUNC_OUTPUT        fu_out [NUM_FU],
  output logic [NUM_FU-1:0] fu_sel,
  output FUNC_OUTPUT        cdb [CDB_WIDTH],
  output logic [CNT_W-1:0]  cdb_count
);

  logic [PTR_W-1:0]     r_rr_ptr;
  FUNC_OUTPUT           r_cdb [CDB_WIDTH];
  logic [CNT_W-1:0]     r_cdb_count;

  logic                 w_block;
  logic [NUM_FU-1:0]    w_req;
  logic [NUM_FU-1:0]    w_grant;
  logic [NUM_FU-1:0]    w_slot_oh [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] w_slot_valid;
  logic [PTR_W-1:0]     w_next_ptr;
  FUNC_OUTPUT           w_cdb_next [CDB_WIDTH];
  logic [CNT_W-1:0]     w_count_next;

  // Masking requests makes reset/squash/stall yield no grants, empty slots and a held pointer
  always_comb begin
    w_block = reset | squash | cdb_stall;
    for (int i = 0; i < int'(NUM_FU); i++) w_req[i] = fu_out[i].valid & ~w_block;
  end

  rr_select_k #(
    .N (NUM_FU),
    .K (CDB_WIDTH)
  ) u_rr_select (
    .i_req        (w_req),
    .i_ptr        (r_rr_ptr),
    .o_grant      (w_grant),
    .o_slot_oh    (w_slot_oh),
    .o_slot_valid (w_slot_valid),
    .o_next_ptr   (w_next_ptr)
  );

  assign fu_sel = w_grant;

  // Slot payload mux; the whole result is copied, unused slots stay all-zero
  always_comb begin
    w_count_next = '0;
    for (int k = 0; k < int'(CDB_WIDTH); k++) begin
      w_cdb_next[k] = '0;
      for (int i = 0; i < int'(NUM_FU); i++) begin
        if (w_slot_oh[k][i]) w_cdb_next[k] = fu_out[i];
      end
      if (w_slot_valid[k]) w_count_next = w_count_next + CNT_W'(1);
    end
  end

  // Output registers and round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_cdb_count <= '0;
      for (int k = 0; k < int'(CDB_WIDTH); k++) r_cdb[k] <= '0;
    end else begin
      r_rr_ptr    <= w_next_ptr;
      r_cdb_count <= w_count_next;
      for (int k = 0; k < int'(CDB_WIDTH); k++) r_cdb[k] <= w_cdb_next[k];
    end
  end

  assign cdb       = r_cdb;
  assign cdb_count = r_cdb_count;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (NUM_FU=4, CDB_WIDTH=2) with an expected-CDB
// scoreboard and a small behavioural multiplier FU on port 0.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int unsigned NF        = 4;
  localparam int unsigned CW        = 2;
  localparam int unsigned NUM_STAGE = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          squash;
  logic          cdb_stall;
  FUNC_OUTPUT    fu_out [NF];
  logic [NF-1:0] fu_sel;
  FUNC_OUTPUT    cdb [CW];
  logic [1:0]    cdb_count;

  always #5 clock = ~clock;

  cdb_arbiter #(
    .NUM_FU    (NF),
    .CDB_WIDTH (CW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .squash    (squash),
    .cdb_stall (cdb_stall),
    .fu_out    (fu_out),
    .fu_sel    (fu_sel),
    .cdb       (cdb),
    .cdb_count (cdb_count)
  );

  typedef struct {
    FUNC_OUTPUT s0;
    FUNC_OUTPUT s1;
    logic [1:0] cnt;
  } exp_t;

  exp_t          sb [$];
  int            checks = 0;
  int            errors = 0;
  int            n42    = 0;
  logic [NF-1:0] last_sel;

  function automatic FUNC_OUTPUT mk(input logic [5:0] d, input logic [31:0] v, input logic vv);
    FUNC_OUTPUT r;
    r             = '0;
    r.valid       = 1'b1;
    r.value_valid = vv;
    r.rob_idx     = d[4:0];
    r.dest_prf    = d;
    r.value       = v;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < int'(NF); i++) fu_out[i] = '0;
  endtask

  // Inputs are already driven (posedge+1); check the grant, queue the expected
  // broadcast, then compare the CDB just after the next edge.
  task automatic cycle(input logic [NF-1:0] esel, input FUNC_OUTPUT e0,
                       input FUNC_OUTPUT e1, input logic [1:0] ecnt);
    exp_t e;
    #1;
    chk("fu_sel", 64'(fu_sel), 64'(esel));
    last_sel = fu_sel;
    e.s0  = e0;
    e.s1  = e1;
    e.cnt = ecnt;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      chk("cdb0", 64'(cdb[0]), 64'(e.s0));
      chk("cdb1", 64'(cdb[1]), 64'(e.s1));
      chk("cdb_count", 64'(cdb_count), 64'(e.cnt));
    end
    if (cdb[0].valid === 1'b1 && cdb[0].value === 32'd42) n42++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    FUNC_OUTPUT z, f, a, b, c, s, g, h0, h1, m, q [NF];
    logic [31:0] prod;
    int  cnt, sent;
    logic m_valid, m_ready, busy;

    z = '0;
    reset = 1'b1; squash = 1'b0; cdb_stall = 1'b0;
    idle_all();
    fu_out[0] = mk(6'd1, 32'h0000_1111, 1'b1);
    @(posedge clock);
    #1;
    // Reset wins over a pending request
    cycle(4'b0000, z, z, 2'd0);
    chk("rr_ptr_reset", 64'(dut.r_rr_ptr), 64'(0));

    reset = 1'b0;
    idle_all();
    cycle(4'b0000, z, z, 2'd0);

    // Single requester FU2
    f = mk(6'd5, 32'h0000_DEAD, 1'b1);
    fu_out[2] = f;
    cycle(4'b0100, f, z, 2'd1);
    chk("rr_ptr_fu2", 64'(dut.r_rr_ptr), 64'(3));

    // Wrap-around from rr_ptr=3: FU3 first, then FU0
    idle_all();
    a = mk(6'd10, 32'h0000_A0A0, 1'b1);
    b = mk(6'd13, 32'h0000_B3B3, 1'b1);
    fu_out[0] = a;
    fu_out[3] = b;
    cycle(4'b1001, b, a, 2'd2);
    chk("rr_ptr_wrap", 64'(dut.r_rr_ptr), 64'(1));

    // x0 destination: value_valid=0 passes through unchanged
    idle_all();
    c = mk(6'd0, 32'h0000_0777, 1'b0);
    fu_out[3] = c;
    cycle(4'b1000, c, z, 2'd1);
    chk("rr_ptr_x0", 64'(dut.r_rr_ptr), 64'(0));

    // All four requesting every cycle: alternate halves
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'(NF); i++) begin
        q[i] = mk(6'(20 + i), 32'(32'h1000 * (r + 1) + i), 1'b1);
        fu_out[i] = q[i];
      end
      if (r == 1) cycle(4'b1100, q[2], q[3], 2'd2);
      else        cycle(4'b0011, q[0], q[1], 2'd2);
    end
    chk("rr_ptr_all4", 64'(dut.r_rr_ptr), 64'(2));

    // Stall for two cycles with FU1 pending, then release
    idle_all();
    s = mk(6'd30, 32'h0000_5151, 1'b1);
    fu_out[1] = s;
    cdb_stall = 1'b1;
    cycle(4'b0000, z, z, 2'd0);
    cycle(4'b0000, z, z, 2'd0);
    chk("rr_ptr_stall", 64'(dut.r_rr_ptr), 64'(2));
    cdb_stall = 1'b0;
    cycle(4'b0010, s, z, 2'd1);
    chk("rr_ptr_unstall", 64'(dut.r_rr_ptr), 64'(2));

    // Broadcast of FU2, then squash against FU0/FU1
    idle_all();
    g = mk(6'd40, 32'h0000_6262, 1'b1);
    fu_out[2] = g;
    cycle(4'b0100, g, z, 2'd1);
    idle_all();
    h0 = mk(6'd41, 32'h0000_7070, 1'b1);
    h1 = mk(6'd42, 32'h0000_7171, 1'b1);
    fu_out[0] = h0;
    fu_out[1] = h1;
    squash = 1'b1;
    cycle(4'b0000, z, z, 2'd0);
    chk("rr_ptr_squash", 64'(dut.r_rr_ptr), 64'(3));
    squash = 1'b0;
    cycle(4'b0011, h0, h1, 2'd2);
    chk("rr_ptr_post_squash", 64'(dut.r_rr_ptr), 64'(2));
    idle_all();
    cycle(4'b0000, z, z, 2'd0);

    // Multiplier FU on port 0: 7*6 through NUM_STAGE stages, held until sel
    prod = 32'(7 * 6);
    m = mk(6'd50, prod, 1'b1);
    m_valid = 1'b0; m_ready = 1'b0; busy = 1'b1; cnt = int'(NUM_STAGE); sent = 0;
    n42 = 0;
    for (int t = 0; t < 10; t++) begin
      fu_out[0] = m_valid ? m : z;
      if (m_valid) cycle(4'b0001, m, z, 2'd1);
      else         cycle(4'b0000, z, z, 2'd0);
      if (m_valid) begin
        if (last_sel[0]) begin
          m_valid = 1'b0;
          m_ready = 1'b1;
          busy    = 1'b0;
          sent++;
        end
      end else if (busy) begin
        cnt--;
        if (cnt == 0) m_valid = 1'b1;
      end
    end
    chk("mult_sent", 64'(sent), 64'(1));
    chk("mult_ready", 64'(m_ready), 64'(1));
    chk("mult_bcast_once", 64'(n42), 64'(1));
    chk("rr_ptr_mult", 64'(dut.r_rr_ptr), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
